// File: rtl/ov7670_pkg.sv
// Shared types and geometry helpers for the OV7670 capture path.
package ov7670_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} cap_state_e;

  localparam int QVGA_H = 320;
  localparam int QVGA_V = 240;
  localparam int VGA_H  = 640;
  localparam int VGA_V  = 480;

  function automatic int out_pixels(input int h, input int v, input int d);
    return (h / d) * (v / d);
  endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Assembles consecutive camera bytes into 16-bit pixels with optional byte swap.
module ov7670_byte_pair (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic        swap,
  input  logic [7:0]  data,
  output logic        phase,
  output logic        pixel_valid,
  output logic [15:0] pixel
);

  logic [7:0] first_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= 1'b0;
    end else if (clear) begin
      phase <= 1'b0;
    end else if (byte_en) begin
      phase <= ~phase;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_en && !phase) begin
      first_byte <= data;
    end
  end

  // Pixel is presented combinationally with the second byte so the writer registers it once.
  assign pixel_valid = byte_en & phase;
  assign pixel       = swap ? {data, first_byte} : {first_byte, data};

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// Frame-synchronised OV7670 capture: byte pairing, decimation and sequential framebuffer writes.
module ov7670_capture_ctrl
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 1,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              swap,
  input  logic              href,
  input  logic              vsync,
  input  logic [7:0]        data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_count,
  output logic              busy
);

  localparam int OUT_PIXELS = out_pixels(H_ACTIVE, V_ACTIVE, DECIM);
  localparam int XW = $clog2(H_ACTIVE + 1) + 1;
  localparam int YW = $clog2(V_ACTIVE + 1) + 1;
  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
  localparam logic [XW-1:0] X_MASK = XW'(DECIM - 1);
  localparam logic [YW-1:0] Y_MASK = YW'(DECIM - 1);

  if ((2 ** ADDR_W) < OUT_PIXELS) begin : g_addr_check
    $error("ADDR_W too small for the decimated frame");
  end

  cap_state_e        state;
  logic              vsync_d, href_d, swap_lat, skip_line, err;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              phase, pixel_valid;
  logic [15:0]       pixel;
  logic              frame_start, frame_end, line_end, href_fall, byte_en, keep, line_bad;

  // Counters saturate so an overlong line or frame can never wrap back into range.
  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (&v) ? v : v + XW'(1);
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (&v) ? v : v + YW'(1);
  endfunction

  assign href_fall   = href_d & ~href & ~vsync;
  assign frame_start = (state == SYNC) & vsync_d & ~vsync;
  assign frame_end   = (state == CAPTURE) & ~vsync_d & vsync;
  assign byte_en     = (state == CAPTURE) & href & ~vsync & ~skip_line;
  assign line_end    = (state == CAPTURE) & href_fall & ~skip_line;
  assign keep        = (x < X_END) & (y < Y_END) & ((x & X_MASK) == '0) & ((y & Y_MASK) == '0);
  assign line_bad    = (x != X_END) | phase;

  ov7670_byte_pair u_pair (
    .clk         (pclk),
    .reset       (reset),
    .clear       (frame_start | line_end),
    .byte_en     (byte_en),
    .swap        (swap_lat),
    .data        (data),
    .phase       (phase),
    .pixel_valid (pixel_valid),
    .pixel       (pixel)
  );

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      swap_lat    <= 1'b0;
      skip_line   <= 1'b0;
      err         <= 1'b0;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      href_d     <= href;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= SYNC;
            busy  <= 1'b1;
          end
        end
        SYNC: begin
          if (frame_start) begin
            state     <= CAPTURE;
            swap_lat  <= swap;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            err       <= 1'b0;
            // A line already in flight when the frame opens is dropped until href falls.
            skip_line <= href;
          end
        end
        CAPTURE: begin
          if (frame_end) begin
            frame_done  <= 1'b1;
            frame_err   <= err | (y != Y_END);
            frame_count <= frame_count + 8'd1;
            state       <= enable ? SYNC : IDLE;
            busy        <= enable;
          end else if (skip_line) begin
            if (href_fall) skip_line <= 1'b0;
          end else if (line_end) begin
            x <= '0;
            y <= sat_inc_y(y);
            if (line_bad) err <= 1'b1;
          end else if (pixel_valid) begin
            x <= sat_inc_x(x);
            if (keep) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= pixel;
              addr      <= addr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Scoreboard bench: full-rate and 2x-decimated instances share one camera stimulus stream.
module tb_ov7670_capture_ctrl;

  localparam int H = 8;
  localparam int V = 4;

  logic        pclk, reset, enable, swap, href, vsync;
  logic [7:0]  data;
  logic        we1, we2, done1, done2, err1, err2, busy1, busy2;
  logic [16:0] addr1, addr2;
  logic [15:0] wd1, wd2;
  logic [7:0]  cnt1, cnt2;

  logic [63:0] q1[$], q2[$], qd1[$], qd2[$];
  int n_chk = 0, n_bad = 0;
  int a1 = 0, a2 = 0, fcnt = 0;
  bit mon_on = 1'b1;

  ov7670_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(17)) dut1 (
    .pclk(pclk), .reset(reset), .enable(enable), .swap(swap), .href(href), .vsync(vsync),
    .data(data), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1), .frame_done(done1),
    .frame_err(err1), .frame_count(cnt1), .busy(busy1));

  ov7670_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .ADDR_W(17)) dut2 (
    .pclk(pclk), .reset(reset), .enable(enable), .swap(swap), .href(href), .vsync(vsync),
    .data(data), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2), .frame_done(done2),
    .frame_err(err2), .frame_count(cnt2), .busy(busy2));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (mon_on) begin
      if (we1) begin
        if (q1.size() == 0) chk("wr1_extra", 64'(we1), 64'd0);
        else chk("wr1", 64'({addr1, wd1}), q1.pop_front());
      end
      if (we2) begin
        if (q2.size() == 0) chk("wr2_extra", 64'(we2), 64'd0);
        else chk("wr2", 64'({addr2, wd2}), q2.pop_front());
      end
      if (done1) begin
        if (qd1.size() == 0) chk("done1_extra", 64'(done1), 64'd0);
        else chk("done1", 64'({err1, cnt1}), qd1.pop_front());
      end
      if (done2) begin
        if (qd2.size() == 0) chk("done2_extra", 64'(done2), 64'd0);
        else chk("done2", 64'({err2, cnt2}), qd2.pop_front());
      end
    end
  end

  task automatic drive(input bit vs, input bit hr, input logic [7:0] d);
    vsync = vs;
    href  = hr;
    data  = d;
    @(negedge pclk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_we", 64'(we1), 64'd0);
    chk("rst_addr", 64'(addr1), 64'd0);
    chk("rst_wdata", 64'(wd1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_count", 64'(cnt1), 64'd0);
    chk("rst_busy2", 64'(busy2), 64'd0);
    @(negedge pclk);
    reset = 1'b1;
    q1.delete(); q2.delete(); qd1.delete(); qd2.delete();
    fcnt   = 0;
    mon_on = 1'b1;
  endtask

  // One camera frame: vsync pulse, V lines of 2*H bytes, closing vsync rise.
  task automatic send_frame(input bit cap, input bit sw, input int bad_line, input int tog_line,
                            input int en_line, input bit en_val, input int rst_line);
    logic [7:0]  b, prev;
    logic [15:0] px;
    int nb, x;
    bit ferr;
    ferr = 1'b0;
    prev = 8'd0;
    if (cap) begin a1 = 0; a2 = 0; end
    repeat (3) drive(1'b1, 1'b0, 8'd0);
    repeat (3) drive(1'b0, 1'b0, 8'd0);
    for (int y = 0; y < V; y++) begin
      if (y == tog_line) swap = ~swap;
      if (y == en_line) enable = en_val;
      nb = (y == bad_line) ? 15 : 2 * H;
      if (y == bad_line) ferr = 1'b1;
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        if ((i % 2 == 1) && cap) begin
          x  = i / 2;
          px = sw ? {b, prev} : {prev, b};
          q1.push_back(64'({17'(a1), px}));
          a1++;
          if ((x % 2 == 0) && (y % 2 == 0)) begin
            q2.push_back(64'({17'(a2), px}));
            a2++;
          end
        end
        if (y == rst_line && i == 5) do_reset();
        drive(1'b0, 1'b1, b);
        prev = b;
      end
      repeat (3) drive(1'b0, 1'b0, 8'd0);
    end
    if (cap) begin
      fcnt = (fcnt + 1) % 256;
      qd1.push_back(64'({ferr, 8'(fcnt)}));
      qd2.push_back(64'({ferr, 8'(fcnt)}));
    end
    repeat (3) drive(1'b1, 1'b0, 8'd0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; swap = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'd0;
    @(negedge pclk);
    chk("init_we", 64'(we1), 64'd0);
    chk("init_addr", 64'(addr1), 64'd0);
    chk("init_wdata", 64'(wd1), 64'd0);
    chk("init_done", 64'(done1), 64'd0);
    chk("init_err", 64'(err1), 64'd0);
    chk("init_count", 64'(cnt1), 64'd0);
    chk("init_busy", 64'(busy1), 64'd0);
    chk("init_busy2", 64'(busy2), 64'd0);
    repeat (2) @(negedge pclk);
    reset  = 1'b1;
    enable = 1'b1;

    send_frame(1'b1, 1'b0, -1, -1, -1, 1'b0, -1);
    swap = 1'b1;
    send_frame(1'b1, 1'b1, -1, 1, -1, 1'b0, -1);
    send_frame(1'b1, 1'b0, 2, -1, -1, 1'b0, -1);
    send_frame(1'b1, 1'b0, -1, -1, 1, 1'b0, -1);
    chk("idle_busy", 64'(busy1), 64'd0);
    chk("idle_busy2", 64'(busy2), 64'd0);
    send_frame(1'b0, 1'b0, -1, -1, 2, 1'b1, -1);
    chk("armed_busy", 64'(busy1), 64'd1);
    send_frame(1'b1, 1'b0, -1, -1, -1, 1'b0, -1);
    mon_on = 1'b0;
    send_frame(1'b0, 1'b0, -1, -1, -1, 1'b0, 1);
    send_frame(1'b1, 1'b0, -1, -1, -1, 1'b0, -1);

    repeat (5) drive(1'b1, 1'b0, 8'd0);
    chk("q1_left", 64'(q1.size()), 64'd0);
    chk("q2_left", 64'(q2.size()), 64'd0);
    chk("qd1_left", 64'(qd1.size()), 64'd0);
    chk("qd2_left", 64'(qd2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
